// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32 integer register file slice.
// Holds the sweep FSM encoding and the architectural depth choices.
package rv32i_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int REG_ADDR_W = 5;
    localparam int NREG_I     = 32;
    localparam int NREG_E     = 16;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Per-register pending-write flags with two combinational lookup ports.
// Callers qualify set/clear; bit 0 can never be set.
module rv32i_scoreboard
    import rv32i_pkg::*;
#(
    parameter int NREG = NREG_I
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_en,
    input  logic [$clog2(NREG)-1:0] set_idx,
    input  logic                    clr_en,
    input  logic [$clog2(NREG)-1:0] clr_idx,
    input  logic [$clog2(NREG)-1:0] rd1_idx,
    input  logic [$clog2(NREG)-1:0] rd2_idx,
    output logic                    busy1,
    output logic                    busy2
);

    logic [NREG-1:0] bits;
    logic [NREG-1:0] nxt;

    // Set is applied after clear so a new producer wins a same-cycle tie.
    always_comb begin
        nxt = bits;
        if (clr_en) nxt[clr_idx] = 1'b0;
        if (set_en) nxt[set_idx] = 1'b1;
        nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bits <= '0;
        else        bits <= nxt;
    end

    assign busy1 = bits[rd1_idx];
    assign busy2 = bits[rd2_idx];

endmodule

// File: rtl/rv32i_basereg_sb.sv
// Integer register file with RV32E depth option, write-first bypass,
// busy scoreboard and a post-reset zeroing sweep of the array.
module rv32i_basereg_sb
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = NREG_I,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ce_read,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic                  i_wr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [XLEN-1:0]       i_rd,
    input  logic                  i_issue,
    input  logic [REG_ADDR_W-1:0] i_issue_addr,
    output logic [XLEN-1:0]       o_rs1,
    output logic [XLEN-1:0]       o_rs2,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_init_done
);

    localparam int IW = $clog2(NREG);
    localparam logic [IW-1:0] LAST = IW'(NREG - 1);
    localparam logic [REG_ADDR_W-1:0] HI_MASK =
        ~REG_ADDR_W'(NREG - 1);

    // Legal and nonzero: the only addresses that touch storage.
    function automatic logic live(input logic [REG_ADDR_W-1:0] a);
        return ((a & HI_MASK) == '0) && (a != '0);
    endfunction

    state_e                state;
    logic [IW-1:0]         cnt;
    logic                  done_q;
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [XLEN-1:0]       regs [NREG];

    logic          run;
    logic          wq;
    logic          iq;
    logic          v1;
    logic          v2;
    logic          fwd1;
    logic          fwd2;
    logic          sb1;
    logic          sb2;
    logic [IW-1:0] widx;
    logic [IW-1:0] iidx;
    logic [IW-1:0] idx1;
    logic [IW-1:0] idx2;

    assign run  = (state == ST_RUN);
    assign wq   = run && i_wr && live(i_rd_addr);
    assign iq   = run && i_issue && live(i_issue_addr);
    assign widx = i_rd_addr[IW-1:0];
    assign iidx = i_issue_addr[IW-1:0];
    assign idx1 = ra1[IW-1:0];
    assign idx2 = ra2[IW-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_INIT;
            cnt    <= IW'(1);
            done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (cnt == LAST) begin
                        state  <= ST_RUN;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                ST_RUN: begin
                    state  <= ST_RUN;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= ST_INIT;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ra1 <= '0;
            ra2 <= '0;
        end else if (i_ce_read) begin
            ra1 <= i_rs1_addr;
            ra2 <= i_rs2_addr;
        end
    end

    // Storage is not reset; the sweep zeroes it after every reset.
    always_ff @(posedge i_clk) begin
        if (!run)    regs[cnt]  <= '0;
        else if (wq) regs[widx] <= i_rd;
    end

    rv32i_scoreboard #(
        .NREG(NREG)
    ) u_sb (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .set_en  (iq),
        .set_idx (iidx),
        .clr_en  (wq),
        .clr_idx (widx),
        .rd1_idx (idx1),
        .rd2_idx (idx2),
        .busy1   (sb1),
        .busy2   (sb2)
    );

    assign v1   = live(ra1);
    assign v2   = live(ra2);
    assign fwd1 = BYPASS && wq && (i_rd_addr == ra1);
    assign fwd2 = BYPASS && wq && (i_rd_addr == ra2);

    always_comb begin
        o_rs1 = '0;
        o_rs2 = '0;
        if (fwd1)    o_rs1 = i_rd;
        else if (v1) o_rs1 = regs[idx1];
        if (fwd2)    o_rs2 = i_rd;
        else if (v2) o_rs2 = regs[idx2];
    end

    assign o_rs1_busy  = v1 && sb1 && !fwd1;
    assign o_rs2_busy  = v2 && sb2 && !fwd2;
    assign o_init_done = done_q;

endmodule

// File: tb/tb_rv32i_basereg_sb.sv
// Randomized and directed bench for rv32i_basereg_sb in three builds:
// RV32I with bypass, RV32I without bypass, RV32E with bypass.
module tb_rv32i_basereg_sb;

    localparam int NC = 3;
    int nreg_c [NC] = '{32, 32, 16};
    bit byp_c  [NC] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        wr = 1'b0;
    logic        iss = 1'b0;
    logic [4:0]  a1 = '0;
    logic [4:0]  a2 = '0;
    logic [4:0]  rda = '0;
    logic [4:0]  isa = '0;
    logic [31:0] rdd = '0;

    logic [31:0] rs1 [NC];
    logic [31:0] rs2 [NC];
    logic        b1 [NC];
    logic        b2 [NC];
    logic        done [NC];

    always #5 clk = ~clk;

    rv32i_basereg_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_read(ce),
        .i_rs1_addr(a1), .i_rs2_addr(a2), .i_wr(wr),
        .i_rd_addr(rda), .i_rd(rdd), .i_issue(iss),
        .i_issue_addr(isa), .o_rs1(rs1[0]), .o_rs2(rs2[0]),
        .o_rs1_busy(b1[0]), .o_rs2_busy(b2[0]),
        .o_init_done(done[0])
    );

    rv32i_basereg_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_read(ce),
        .i_rs1_addr(a1), .i_rs2_addr(a2), .i_wr(wr),
        .i_rd_addr(rda), .i_rd(rdd), .i_issue(iss),
        .i_issue_addr(isa), .o_rs1(rs1[1]), .o_rs2(rs2[1]),
        .o_rs1_busy(b1[1]), .o_rs2_busy(b2[1]),
        .o_init_done(done[1])
    );

    rv32i_basereg_sb #(.XLEN(32), .NREG(16), .BYPASS(1'b1)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_read(ce),
        .i_rs1_addr(a1), .i_rs2_addr(a2), .i_wr(wr),
        .i_rd_addr(rda), .i_rd(rdd), .i_issue(iss),
        .i_issue_addr(isa), .o_rs1(rs1[2]), .o_rs2(rs2[2]),
        .o_rs1_busy(b1[2]), .o_rs2_busy(b2[2]),
        .o_init_done(done[2])
    );

    // Reference state: architectural contents, pending flags, sweep progress.
    logic [31:0] mem   [NC][32];
    bit          known [NC][32];
    bit          busy  [NC][32];
    int          swp   [NC];
    bit          run   [NC];
    logic [4:0]  cap1;
    logic [4:0]  cap2;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d got=%h want=%h", tag, k, obs, exp);
        end
    endtask

    function automatic bit live(input int k, input logic [4:0] a);
        return (a != 0) && (int'(a) < nreg_c[k]);
    endfunction

    task automatic check_port(input int k, input string tag,
                              input logic [4:0] cap,
                              input logic [31:0] obs,
                              input logic obs_busy);
        bit wq;
        bit fw;
        wq = run[k] && wr && live(k, rda);
        fw = byp_c[k] && wq && (rda == cap);
        if (fw) begin
            chk({tag, "_data"}, k, obs, rdd);
            chk({tag, "_busy"}, k, 32'(obs_busy), 32'd0);
        end else if (!live(k, cap)) begin
            chk({tag, "_data"}, k, obs, 32'd0);
            chk({tag, "_busy"}, k, 32'(obs_busy), 32'd0);
        end else begin
            if (known[k][cap]) chk({tag, "_data"}, k, obs, mem[k][cap]);
            chk({tag, "_busy"}, k, 32'(obs_busy), 32'(busy[k][cap]));
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NC; k++) begin
            chk("init_done", k, 32'(done[k]), 32'(run[k]));
            check_port(k, "rs1", cap1, rs1[k], b1[k]);
            check_port(k, "rs2", cap2, rs2[k], b2[k]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            swp[k] = 1;
            run[k] = 1'b0;
            for (int r = 0; r < 32; r++) busy[k][r] = 1'b0;
        end
        cap1 = '0;
        cap2 = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NC; k++) begin
            if (!run[k]) begin
                mem[k][swp[k]]   = '0;
                known[k][swp[k]] = 1'b1;
                if (swp[k] == nreg_c[k] - 1) run[k] = 1'b1;
                else                         swp[k]++;
            end else begin
                if (wr && live(k, rda)) begin
                    mem[k][rda]   = rdd;
                    known[k][rda] = 1'b1;
                    busy[k][rda]  = 1'b0;
                end
                if (iss && live(k, isa)) busy[k][isa] = 1'b1;
            end
        end
        if (ce) begin
            cap1 = a1;
            cap2 = a2;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic c, input logic [4:0] x1,
                         input logic [4:0] x2, input logic w,
                         input logic [4:0] d, input logic [31:0] v,
                         input logic i, input logic [4:0] ia);
        ce = c; a1 = x1; a2 = x2;
        wr = w; rda = d; rdd = v;
        iss = i; isa = ia;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 6));
    endfunction

    task automatic rand_inputs();
        drive(1'($urandom_range(0, 1)), raddr(), raddr(),
              1'($urandom_range(0, 1)), raddr(), $urandom,
              1'($urandom_range(0, 2) == 0), raddr());
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Asynchronous assertion between edges; outputs must react at once.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
    endtask

    task automatic sweep_and_count();
        int cyc;
        cyc = 0;
        rst_n = 1'b1;
        while (!done[0] && cyc < 100) begin
            rand_inputs();
            step();
            cyc++;
        end
        chk("sweep_len", 0, 32'(cyc), 32'd31);
    endtask

    initial begin
        for (int k = 0; k < NC; k++)
            for (int r = 0; r < 32; r++) known[k][r] = 1'b0;
        model_reset();
        idle();
        step();
        step();

        sweep_and_count();
        idle();
        step();

        drive(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        idle();
        step();

        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        idle();
        step();

        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0);
        step();
        idle();
        step();

        drive(1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step();
        idle();
        step();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h000000A5, 1'b0, 5'd0);
        step();
        idle();
        step();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0000005A, 1'b1, 5'd9);
        step();
        idle();
        step();
        chk("sb_set_wins", 0, 32'(b2[0]), 32'd1);

        drive(1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 32'h00000044, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h000000FF, 1'b1, 5'd20);
        step();
        drive(1'b1, 5'd20, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        idle();
        step();
        chk("rv32e_x20", 2, rs1[2], 32'd0);
        chk("rv32e_x4", 2, rs2[2], 32'h00000044);

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end

        async_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            rand_inputs();
            step();
        end
        async_reset();
        sweep_and_count();

        for (int n = 0; n < 150; n++) begin
            rand_inputs();
            step();
        end
        async_reset();
        sweep_and_count();
        for (int n = 0; n < 100; n++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_basereg_sb.md
Name: rv32i_basereg_sb

Overview:
Parametrised successor of the integer base register file. Adds RV32E depth selection, optional write-first bypass, and a per-register busy scoreboard for load-use and long-latency hazards. Adds a post-reset hardware sweep that zeroes the array. Sits between DECODE (stage 2, read) and WRITEBACK (stage 5, write); the hazard unit consumes the busy flags.

Parameters:
XLEN, 32, data width of each register
NREG, 32, architectural register count; legal values 32 (RV32I) or 16 (RV32E)
BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read outputs; 0 = read returns the array value

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_ce_read  in  1  stage-2 enable; captures read addresses
i_rs1_addr  in  5  source register 1 address
i_rs2_addr  in  5  source register 2 address
i_wr  in  1  writeback enable
i_rd_addr  in  5  writeback destination address
i_rd  in  XLEN  writeback data
i_issue  in  1  instruction issued with a pending destination; mark it busy
i_issue_addr  in  5  destination address being marked busy
o_rs1  out  XLEN  source register 1 value
o_rs2  out  XLEN  source register 2 value
o_rs1_busy  out  1  source register 1 has a pending write
o_rs2_busy  out  1  source register 2 has a pending write
o_init_done  out  1  sweep complete; block accepts traffic

Behaviour:
- Reset (async assert, sync release): FSM=INIT, sweep counter=1, scoreboard all 0, captured rs1/rs2 addresses=0. Resulting outputs: o_rs1=o_rs2=0, o_rs1_busy=o_rs2_busy=0, o_init_done=0.
- FSM states:
  - INIT: writes 0 to array[counter] each cycle, counter 1..NREG-1. On the cycle that writes NREG-1, the next state is RUN. INIT lasts NREG-1 cycles after reset release. o_init_done=1 in RUN only.
  - RUN: terminal state. Only reset returns the FSM to INIT, including reset mid-sweep.
- During INIT, i_wr and i_issue are ignored. i_ce_read still captures addresses. Outputs read the array as it is being swept.
- Read: addresses are registered on i_clk when i_ce_read=1 and held otherwise. The data path after that register is combinational. Address 0 always reads 0.
- Address legality: an address with any bit at or above log2(NREG) set (addresses 16..31 when NREG=16) is out of range. Out of range on a read gives 0 and busy=0. Out of range on a write or issue is ignored.
- Write: synchronous, on i_wr=1 in RUN with a legal, nonzero i_rd_addr.
- Bypass (BYPASS=1): if a write qualifies this cycle and i_rd_addr equals a captured read address, that output equals i_rd in the same cycle. With BYPASS=0 the new value appears the cycle after the write.
- Scoreboard: one bit per register 1..NREG-1; bit 0 is constant 0.
  - A qualified i_issue sets bit[i_issue_addr].
  - A qualified i_wr clears bit[i_rd_addr].
  - Same address, same cycle: set wins (new producer in flight).
- Busy outputs: o_rsN_busy = bit[captured addr]. When BYPASS=1 it is masked to 0 on the cycle a qualified write to that address is also forwarded.
- Widths: array is XLEN-wide. Sweep counter is log2(NREG) bits and stops at NREG-1 with no wrap.

Decomposition:
- Shared package rv32i_pkg holds: FSM state enum (INIT, RUN), REG_ADDR_W=5, and constants NREG_I=32 and NREG_E=16.
- One natural sub-module, rv32i_scoreboard: set/clear bit vector with combinational lookup for two read ports.
- Array, sweep FSM and bypass mux stay in the top module.

Test Plan:
- Reset release, NREG=32 -> o_init_done=0 for 31 cycles then 1. Reading x5 and x31 afterwards returns 0.
- RUN: write x7=0xDEADBEEF, then i_ce_read with rs1=7, rs2=0 -> o_rs1=0xDEADBEEF, o_rs2=0.
- BYPASS=1: rs1=3 captured; same cycle as i_wr x3=0x12345678 -> o_rs1=0x12345678 immediately, o_rs1_busy=0. BYPASS=0 -> old value that cycle, new value next cycle.
- Scoreboard:
  - i_issue x9, then rs2=9 -> o_rs2_busy=1.
  - i_wr x9=0xA5 -> busy=0 next cycle.
  - Issue x9 and write x9 in the same cycle -> busy stays 1.
- NREG=16: write x20=0xFF and issue x20, then read x20 -> o_rs1=0, busy=0. x4 is unaffected.
- Assert i_rst_n mid-sweep (cycle 10) and mid-RUN after writes -> scoreboard clears, o_init_done drops at once, and a full 31-cycle sweep restarts.
